// File: rtl/mx_wb_pipe_pkg.sv
// mx_pkg: shared defaults, write-back source encodings and helpers
// for the write-back pipe (mx_wb_pipe) and its selector (mx_nsel).
package mx_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned RD_W_DEF   = 5;

  typedef enum logic [3:0] {
    SRC_PC  = 4'd0,
    SRC_DM  = 4'd1,
    SRC_ALU = 4'd2,
    SRC_IMM = 4'd3
  } src_e;

  // Register index is non-zero (r0 writes are dropped); indices up to 16 bits.
  function automatic logic rd_nonzero(input logic [15:0] rd);
    return rd != '0;
  endfunction

endpackage

// File: rtl/mx_wb_pipe_nsel.sv
// mx_nsel: combinational N_SRC-to-1 word selector with out-of-range flag.
// Indices >= N_SRC fall back to source DEFAULT_SRC.
module mx_nsel #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned N_SRC       = 4,
  parameter int unsigned SEL_W       = $clog2(N_SRC),
  parameter int unsigned DEFAULT_SRC = 0
) (
  input  logic [N_SRC*DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_of_range
);

  // Pick the indexed source, or the default source when no index matches.
  always_comb begin
    out_data     = in_data[DEFAULT_SRC*DATA_W +: DATA_W];
    out_of_range = 1'b1;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      if (in_sel == SEL_W'(k)) begin
        out_data     = in_data[k*DATA_W +: DATA_W];
        out_of_range = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mx_wb_pipe.sv
// mx_wb_pipe: registered write-back source mux with valid/ready handshake
// toward the register bank.
// Optional build macro MX_WB_SKID_EN: adds a skid entry so in_ready is
// registered (no combinational path from out_ready).
module mx_wb_pipe
  import mx_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned N_SRC       = 4,
  parameter int unsigned SEL_W       = $clog2(N_SRC),
  parameter int unsigned RD_W        = RD_W_DEF,
  parameter int unsigned DEFAULT_SRC = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_SRC*DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic [RD_W-1:0]         in_rd,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [RD_W-1:0]         out_rd,
  output logic                    out_we,
  output logic                    sel_err
);

  logic [DATA_W-1:0] sel_data;
  logic              sel_oor;
  logic              acc;
  logic              pop;

  mx_nsel #(
    .DATA_W      (DATA_W),
    .N_SRC       (N_SRC),
    .SEL_W       (SEL_W),
    .DEFAULT_SRC (DEFAULT_SRC)
  ) u_nsel (
    .in_data      (in_data),
    .in_sel       (in_sel),
    .out_data     (sel_data),
    .out_of_range (sel_oor)
  );

  assign acc = in_valid && in_ready;
  assign pop = out_valid && out_ready;

  // Write enable from registered state only; suppressed while in reset.
  assign out_we = rst_n && out_valid && rd_nonzero(16'(out_rd));

`ifdef MX_WB_SKID_EN
  logic              skid_full;
  logic [DATA_W-1:0] skid_data;
  logic [RD_W-1:0]   skid_rd;

  assign in_ready = !skid_full;

  // Output register plus one skid entry; the skid entry drains first to keep order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_rd    <= '0;
      skid_full <= 1'b0;
      skid_data <= '0;
      skid_rd   <= '0;
      sel_err   <= 1'b0;
    end else begin
      if (acc && sel_oor) sel_err <= 1'b1;
      if (skid_full) begin
        if (pop) begin
          out_data  <= skid_data;
          out_rd    <= skid_rd;
          skid_full <= 1'b0;
        end
      end else if (acc) begin
        if (!out_valid || pop) begin
          out_valid <= 1'b1;
          out_data  <= sel_data;
          out_rd    <= in_rd;
        end else begin
          skid_full <= 1'b1;
          skid_data <= sel_data;
          skid_rd   <= in_rd;
        end
      end else if (pop) begin
        out_valid <= 1'b0;
      end
    end
  end
`else
  assign in_ready = !out_valid || out_ready;

  // Single output register: load on accept, clear valid on a pop without accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_rd    <= '0;
      sel_err   <= 1'b0;
    end else begin
      if (acc && sel_oor) sel_err <= 1'b1;
      if (acc) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_rd    <= in_rd;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mx_wb_pipe.sv
// tb_mx_wb_pipe: self-checking bench for mx_wb_pipe (N_SRC=4 instance with a
// queue reference model, plus an N_SRC=3 instance for out-of-range selection).
module tb_mx_wb_pipe;
  import mx_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instance A: N_SRC=4, DEFAULT_SRC=0
  logic         a_in_valid = 1'b0;
  logic         a_in_ready;
  logic [127:0] a_in_data = '0;
  logic [1:0]   a_in_sel = '0;
  logic [4:0]   a_in_rd = '0;
  logic         a_out_valid;
  logic         a_out_ready = 1'b1;
  logic [31:0]  a_out_data;
  logic [4:0]   a_out_rd;
  logic         a_out_we;
  logic         a_sel_err;

  // Instance B: N_SRC=3, DEFAULT_SRC=SRC_ALU
  logic         b_in_valid = 1'b0;
  logic         b_in_ready;
  logic [95:0]  b_in_data = '0;
  logic [1:0]   b_in_sel = '0;
  logic [4:0]   b_in_rd = '0;
  logic         b_out_valid;
  logic         b_out_ready = 1'b1;
  logic [31:0]  b_out_data;
  logic [4:0]   b_out_rd;
  logic         b_out_we;
  logic         b_sel_err;

  mx_wb_pipe #(.DATA_W(32), .N_SRC(4), .RD_W(5), .DEFAULT_SRC(0)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_sel(a_in_sel), .in_rd(a_in_rd),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_rd(a_out_rd), .out_we(a_out_we), .sel_err(a_sel_err)
  );

  mx_wb_pipe #(.DATA_W(32), .N_SRC(3), .RD_W(5), .DEFAULT_SRC(2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_sel(b_in_sel), .in_rd(b_in_rd),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_rd(b_out_rd), .out_we(b_out_we), .sel_err(b_sel_err)
  );

  // Reference model: FIFO of pending writes, head is what out_* presents.
  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
  } ent_t;

  ent_t        q[$];
  logic [31:0] last_data = '0;
  logic [4:0]  last_rd = '0;
  logic [31:0] src [4];
  logic [31:0] b_src [3];

`ifdef MX_WB_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  function automatic bit model_ready(input logic ordy);
    if (CAP == 2) return q.size() < 2;
    return (q.size() == 0) || ordy;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    bit v;
    v = q.size() != 0;
    if (v) begin
      last_data = q[0].data;
      last_rd   = q[0].rd;
    end
    check("out_valid", a_out_valid, v);
    check("out_data", a_out_data, last_data);
    check("out_rd", a_out_rd, last_rd);
    check("out_we", a_out_we, v && (last_rd != 0));
    check("sel_err", a_sel_err, 1'b0);
  endtask

  // One clock of instance A: drive, check in_ready, advance, update model, check.
  task automatic a_cycle(input logic v, input logic [1:0] sel, input logic [4:0] rd,
                         input logic ordy);
    ent_t e;
    bit   rdy, acc, pop;
    a_in_valid  = v;
    a_in_sel    = sel;
    a_in_rd     = rd;
    a_out_ready = ordy;
    a_in_data   = {src[3], src[2], src[1], src[0]};
    #1;
    rdy = model_ready(ordy);
    check("in_ready", a_in_ready, rdy);
    acc    = v && rdy;
    pop    = (q.size() != 0) && ordy;
    e.data = src[sel];
    e.rd   = rd;
    @(posedge clk);
    #1;
    if (pop) void'(q.pop_front());
    if (acc) q.push_back(e);
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("we_in_rst", a_out_we, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    last_data = '0;
    last_rd   = '0;
    check_outputs();
    check("b_valid_rst", b_out_valid, 1'b0);
    check("b_sel_err_rst", b_sel_err, 1'b0);
  endtask

  initial begin
    src[0] = 32'h0000_0104;
    src[1] = 32'hDEAD_BEEF;
    src[2] = 32'h0000_002A;
    src[3] = 32'hFFFF_FFF0;
    b_src[0] = 32'h1111_0000;
    b_src[1] = 32'h2222_0001;
    b_src[2] = 32'h3333_0002;
    b_in_data = {b_src[2], b_src[1], b_src[0]};

    @(posedge clk);
    #1;
    do_reset();

    // Single transfer from the data-memory source
    a_cycle(1'b1, 2'd1, 5'd7, 1'b1);
    check("tp1_data", a_out_data, 32'hDEAD_BEEF);
    check("tp1_we", a_out_we, 1'b1);

    // Back-to-back stream, no bubbles
    a_cycle(1'b1, 2'd0, 5'd3, 1'b1);
    check("b2b_pc", a_out_data, 32'h0000_0104);
    a_cycle(1'b1, 2'd2, 5'd4, 1'b1);
    check("b2b_alu", a_out_data, 32'h0000_002A);
    a_cycle(1'b1, 2'd3, 5'd5, 1'b1);
    check("b2b_imm", a_out_data, 32'hFFFF_FFF0);
    a_cycle(1'b0, 2'd0, 5'd0, 1'b1);

    // Stall with a second request waiting upstream
    a_cycle(1'b1, 2'd2, 5'd9, 1'b0);
    repeat (3) a_cycle(1'b1, 2'd3, 5'd10, 1'b0);
    check("stall_data", a_out_data, 32'h0000_002A);
    a_cycle(1'b1, 2'd3, 5'd10, 1'b1);
    check("stall_rd2", a_out_rd, 5'd10);
    repeat (2) a_cycle(1'b0, 2'd0, 5'd0, 1'b1);

    // Write to r0: handshake completes, no write enable
    a_cycle(1'b1, 2'd2, 5'd0, 1'b1);
    check("r0_valid", a_out_valid, 1'b1);
    check("r0_data", a_out_data, 32'h0000_002A);
    check("r0_we", a_out_we, 1'b0);
    a_cycle(1'b0, 2'd0, 5'd0, 1'b1);

    // Randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      logic [4:0] rd;
      for (int k = 0; k < 4; k++) src[k] = $urandom;
      rd = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
      a_cycle($urandom_range(0, 3) != 0, 2'($urandom), rd, $urandom_range(0, 2) != 0);
    end
    repeat (3) a_cycle(1'b0, 2'd0, 5'd0, 1'b1);

    // Instance B: out-of-range select
    b_in_valid = 1'b0;
    b_in_sel   = 2'd3;
    a_cycle(1'b0, 2'd0, 5'd0, 1'b1);
    check("b_noxfer_err", b_sel_err, 1'b0);
    b_in_valid = 1'b1;
    b_in_rd    = 5'd4;
    a_cycle(1'b0, 2'd0, 5'd0, 1'b1);
    check("b_oor_valid", b_out_valid, 1'b1);
    check("b_oor_data", b_out_data, b_src[2]);
    check("b_oor_err", b_sel_err, 1'b1);
    check("b_oor_we", b_out_we, 1'b1);
    b_in_sel = 2'd1;
    b_in_rd  = 5'd6;
    a_cycle(1'b0, 2'd0, 5'd0, 1'b1);
    check("b_in_range_data", b_out_data, b_src[1]);
    check("b_err_sticky1", b_sel_err, 1'b1);
    b_in_valid = 1'b0;
    repeat (3) a_cycle(1'b0, 2'd0, 5'd0, 1'b1);
    check("b_err_sticky2", b_sel_err, 1'b1);
    check("b_idle_valid", b_out_valid, 1'b0);

    // Reset during a stall discards the pending entry
    src[0] = 32'h0000_0104;
    src[1] = 32'hDEAD_BEEF;
    src[2] = 32'h0000_002A;
    src[3] = 32'hFFFF_FFF0;
    a_cycle(1'b1, 2'd1, 5'd3, 1'b0);
    a_cycle(1'b1, 2'd2, 5'd4, 1'b0);
    a_in_valid = 1'b1;
    do_reset();
    check("rst_valid", a_out_valid, 1'b0);
    check("rst_data", a_out_data, 32'h0);
    check("rst_we", a_out_we, 1'b0);
    a_cycle(1'b0, 2'd0, 5'd0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
